ycbcr422_packer: RTL

// - Downstream of the RGB->YCbCr converter: takes one 4:4:4 YCbCr pixel per clock and packs pixel pairs

---
 rtl/ycbcr422_packer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ycbcr422_packer.sv
// rtl/ycbcr422_packer.sv - packs 4:4:4 YCbCr pixel pairs into YUYV words behind a small FWFT FIFO
// Optional build macro CHROMA_AVG_EN: average the two pixels' chroma instead of keeping pixel 0's.
module ycbcr422_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  iY,
    input  logic [7:0]  iCb,
    input  logic [7:0]  iCr,
    input  logic        iValid,
    input  logic        iSol,
    input  logic        iSof,
    input  logic        iReady,
    input  logic        iClrErr,
    output logic [31:0] oData,
    output logic        oValid,
    output logic        oSof,
    output logic        oOverflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {EVEN, ODD} pair_state_t;

    pair_state_t state, state_nxt;
    logic [7:0]  hold_y, hold_cb, hold_cr;
    logic        hold_sof;
    logic        capture;
    logic        push_nxt;
    logic [31:0] word_nxt;
    logic        sof_nxt;
    logic [7:0]  pair_cb, pair_cr;

    logic        stage_valid;
    logic [31:0] stage_data;
    logic        stage_sof;

    logic [31:0] mem_data [FIFO_DEPTH];
    logic        mem_sof  [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, do_write, drop;

`ifdef CHROMA_AVG_EN
    logic [8:0] sum_cb, sum_cr;
    assign sum_cb  = {1'b0, hold_cb} + {1'b0, iCb} + 9'd1;
    assign sum_cr  = {1'b0, hold_cr} + {1'b0, iCr} + 9'd1;
    assign pair_cb = sum_cb[8:1];
    assign pair_cr = sum_cr[8:1];
`else
    assign pair_cb = hold_cb;
    assign pair_cr = hold_cr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EVEN;
        end else begin
            state <= state_nxt;
        end
    end

    // A start-of-line while a pixel is held closes an odd-length line with a padded word.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        push_nxt  = 1'b0;
        word_nxt  = '0;
        sof_nxt   = 1'b0;
        case (state)
            EVEN: begin
                if (iValid) begin
                    capture   = 1'b1;
                    state_nxt = ODD;
                end
            end
            ODD: begin
                if (iValid) begin
                    push_nxt = 1'b1;
                    sof_nxt  = hold_sof;
                    if (iSol || iSof) begin
                        word_nxt = {hold_cr, hold_y, hold_cb, hold_y};
                        capture  = 1'b1;
                    end else begin
                        word_nxt  = {pair_cr, iY, pair_cb, hold_y};
                        state_nxt = EVEN;
                    end
                end
            end
            default: state_nxt = EVEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_y      <= '0;
            hold_cb     <= '0;
            hold_cr     <= '0;
            hold_sof    <= 1'b0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            stage_sof   <= 1'b0;
        end else begin
            if (capture) begin
                hold_y   <= iY;
                hold_cb  <= iCb;
                hold_cr  <= iCr;
                hold_sof <= iSof;
            end
            stage_valid <= push_nxt;
            stage_data  <= word_nxt;
            stage_sof   <= sof_nxt;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && iReady;
    assign do_write = stage_valid && (!full || pop);
    assign drop     = stage_valid && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_sof[i]  <= 1'b0;
            end
        end else begin
            if (do_write) begin
                mem_data[wr_ptr[AW-1:0]] <= stage_data;
                mem_sof[wr_ptr[AW-1:0]]  <= stage_sof;
                wr_ptr                   <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oOverflow <= 1'b0;
        end else if (drop) begin
            oOverflow <= 1'b1;
        end else if (iClrErr) begin
            oOverflow <= 1'b0;
        end
    end

    assign oValid = !empty;
    assign oData  = mem_data[rd_ptr[AW-1:0]];
    assign oSof   = mem_sof[rd_ptr[AW-1:0]];

endmodule
